// File: rtl/mem_bus_arbiter.sv
// Two-master valid/ready arbiter and sequencer for the shared 2K x 32 RAM and 8-bit port I/O bus.
// Define MEM_ARB_M1_IO_EN to let master 1 reach I/O space; otherwise such accesses are blocked and flagged.
module mem_bus_arbiter #(
    parameter int RAM_AW = 11
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              m0_valid,
    input  logic [31:0]       m0_addr,
    input  logic [31:0]       m0_wdata,
    input  logic [3:0]        m0_wstrb,
    output logic              m0_ready,
    output logic [31:0]       m0_rdata,
    input  logic              m1_valid,
    input  logic [31:0]       m1_addr,
    input  logic [31:0]       m1_wdata,
    input  logic [3:0]        m1_wstrb,
    output logic              m1_ready,
    output logic [31:0]       m1_rdata,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic [3:0]        ram_we,
    output logic              ram_en,
    input  logic [31:0]       ram_rdata,
    output logic [7:0]        port_id,
    output logic [7:0]        out_port,
    output logic              write_strobe,
    output logic              read_strobe,
    input  logic [7:0]        in_port,
    output logic              m1_io_err
);

    typedef enum logic [1:0] {IDLE, ISSUE, DATA} state_t;

    state_t      state;
    logic        grant;
    logic        last_grant;
    logic        req_io;
    logic        req_blocked;
    logic [3:0]  req_wstrb;
    logic [31:0] m0_rdata_q;
    logic [31:0] m1_rdata_q;
    logic        m0_ram_pass;
    logic        m1_ram_pass;

    logic        sel_grant;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [3:0]  sel_wstrb;
    logic        sel_blocked;
    logic [31:0] issue_rdata;

    // Tie-break toward the master that was not served last.
    always_comb begin
        sel_grant = 1'b0;
        if (m0_valid && m1_valid)
            sel_grant = ~last_grant;
        else if (m1_valid)
            sel_grant = 1'b1;
        sel_addr    = sel_grant ? m1_addr  : m0_addr;
        sel_wdata   = sel_grant ? m1_wdata : m0_wdata;
        sel_wstrb   = sel_grant ? m1_wstrb : m0_wstrb;
        sel_blocked = 1'b0;
`ifndef MEM_ARB_M1_IO_EN
        sel_blocked = sel_grant && sel_addr[31];
`endif
    end

    // Upper RAM address bits alias and the byte offset is implied by wstrb.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{sel_addr[30:RAM_AW+2], sel_addr[1:0]};

    assign issue_rdata = (req_io && req_wstrb == 4'd0 && !req_blocked) ? {24'd0, in_port} : 32'd0;

    // RAM read data arrives in DATA straight from the RAM's output register; the
    // select is registered and the value is captured on leaving DATA so it holds.
    assign m0_rdata = m0_ram_pass ? ram_rdata : m0_rdata_q;
    assign m1_rdata = m1_ram_pass ? ram_rdata : m1_rdata_q;

`ifdef MEM_ARB_M1_IO_EN
    assign m1_io_err = 1'b0;
`else
    logic m1_io_err_q;
    assign m1_io_err = m1_io_err_q;
`endif

    // NOTE: all sequential state uses non-blocking assignments so every register
    // samples pre-edge values and simulation matches the synthesized flops.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state        <= IDLE;
            grant        <= 1'b0;
            last_grant   <= 1'b1;
            req_io       <= 1'b0;
            req_blocked  <= 1'b0;
            req_wstrb    <= 4'd0;
            m0_ready     <= 1'b0;
            m1_ready     <= 1'b0;
            m0_rdata_q   <= 32'd0;
            m1_rdata_q   <= 32'd0;
            m0_ram_pass  <= 1'b0;
            m1_ram_pass  <= 1'b0;
            ram_addr     <= '0;
            ram_wdata    <= 32'd0;
            ram_we       <= 4'd0;
            ram_en       <= 1'b0;
            port_id      <= 8'd0;
            out_port     <= 8'd0;
            write_strobe <= 1'b0;
            read_strobe  <= 1'b0;
`ifndef MEM_ARB_M1_IO_EN
            m1_io_err_q  <= 1'b0;
`endif
        end else begin
            ram_en       <= 1'b0;
            ram_we       <= 4'd0;
            write_strobe <= 1'b0;
            read_strobe  <= 1'b0;
            case (state)
                IDLE: begin
                    if (m0_valid || m1_valid) begin
                        grant       <= sel_grant;
                        req_io      <= sel_addr[31];
                        req_blocked <= sel_blocked;
                        req_wstrb   <= sel_wstrb;
                        ram_addr    <= sel_addr[RAM_AW+1:2];
                        ram_wdata   <= sel_wdata;
                        port_id     <= sel_addr[9:2];
                        out_port    <= sel_wdata[7:0];
                        // Slave strobes are registered here so they are high during ISSUE only.
                        if (!sel_addr[31]) begin
                            ram_en <= 1'b1;
                            ram_we <= sel_wstrb;
                        end else if (!sel_blocked) begin
                            write_strobe <= sel_wstrb[0];
                            read_strobe  <= (sel_wstrb == 4'd0);
                        end
`ifndef MEM_ARB_M1_IO_EN
                        if (sel_blocked)
                            m1_io_err_q <= 1'b1;
`endif
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (grant) m1_ready <= 1'b1;
                    else       m0_ready <= 1'b1;
                    if (!req_io && req_wstrb == 4'd0) begin
                        if (grant) m1_ram_pass <= 1'b1;
                        else       m0_ram_pass <= 1'b1;
                    end else if (grant) begin
                        m1_rdata_q <= issue_rdata;
                    end else begin
                        m0_rdata_q <= issue_rdata;
                    end
                    state <= DATA;
                end
                DATA: begin
                    m0_ready <= 1'b0;
                    m1_ready <= 1'b0;
                    if (m0_ram_pass) m0_rdata_q <= ram_rdata;
                    if (m1_ram_pass) m1_rdata_q <= ram_rdata;
                    m0_ram_pass <= 1'b0;
                    m1_ram_pass <= 1'b0;
                    last_grant  <= grant;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: directed transactions push expected responses,
// a negedge monitor pops and compares on every ready pulse.
module tb_mem_bus_arbiter;

    localparam int RAM_AW = 11;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              m0_valid = 1'b0, m1_valid = 1'b0;
    logic [31:0]       m0_addr = '0, m1_addr = '0, m0_wdata = '0, m1_wdata = '0;
    logic [3:0]        m0_wstrb = '0, m1_wstrb = '0;
    logic              m0_ready, m1_ready;
    logic [31:0]       m0_rdata, m1_rdata;
    logic [RAM_AW-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [3:0]        ram_we;
    logic              ram_en;
    logic [31:0]       ram_rdata = '0;
    logic [7:0]        port_id, out_port;
    logic              write_strobe, read_strobe;
    logic [7:0]        in_port = '0;
    logic              m1_io_err;

    mem_bus_arbiter #(.RAM_AW(RAM_AW)) dut (
        .clk(clk), .resetn(resetn),
        .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
        .m0_ready(m0_ready), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_ready(m1_ready), .m1_rdata(m1_rdata),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_en(ram_en),
        .ram_rdata(ram_rdata),
        .port_id(port_id), .out_port(out_port), .write_strobe(write_strobe),
        .read_strobe(read_strobe), .in_port(in_port), .m1_io_err(m1_io_err)
    );

    always #5 clk = ~clk;

    // Byte-write RAM with registered read data, as in the SoC.
    logic [31:0] mem [0:(1<<RAM_AW)-1];
    always @(posedge clk) begin
        if (ram_en) begin
            ram_rdata <= mem[ram_addr];
            for (int b = 0; b < 4; b++)
                if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
    end

    typedef struct {
        bit          m;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   ready_cycles[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   ram_en_cnt = 0, ws_cnt = 0, rs_cnt = 0, ready_cnt = 0;
    logic [RAM_AW-1:0] last_ram_addr = '0;
    logic [3:0]        last_ram_we = '0;
    logic [31:0]       last_ram_wdata = '0;
    logic [7:0]        last_port_id = '0, last_out_port = '0;
    logic              prev_en = 1'b0, prev_ws = 1'b0, prev_rs = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // Monitor: slave-side pulse capture plus scoreboard pop on every ready.
    always @(negedge clk) begin
        if (resetn) begin
            if (ram_en) begin
                check("ram_en_single_cycle", prev_en, 0);
                ram_en_cnt++;
                last_ram_addr  = ram_addr;
                last_ram_we    = ram_we;
                last_ram_wdata = ram_wdata;
            end
            if (write_strobe) begin
                check("write_strobe_single_cycle", prev_ws, 0);
                ws_cnt++;
                last_port_id  = port_id;
                last_out_port = out_port;
            end
            if (read_strobe) begin
                check("read_strobe_single_cycle", prev_rs, 0);
                rs_cnt++;
                last_port_id = port_id;
            end
            if (m0_ready || m1_ready) begin
                ready_cnt++;
                ready_cycles.push_back(cyc);
                check("ready_onehot", m0_ready & m1_ready, 0);
                check("sb_nonempty", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    check("grant", m1_ready, e.m);
                    check("rdata", m1_ready ? m1_rdata : m0_rdata, e.rdata);
                end
            end
        end
        prev_en = ram_en;
        prev_ws = write_strobe;
        prev_rs = read_strobe;
    end

    task automatic drive(input bit m, input logic v, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
        if (m) begin m1_valid = v; m1_addr = a; m1_wdata = d; m1_wstrb = s; end
        else   begin m0_valid = v; m0_addr = a; m0_wdata = d; m0_wstrb = s; end
    endtask

    // One transaction; exp_lat > 0 also checks valid-to-ready latency in edges.
    task automatic txn(input bit m, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [31:0] exp, input bit push,
                       input int exp_lat);
        int  n;
        bit  got;
        if (push) sb.push_back('{m, exp});
        drive(m, 1'b1, a, d, s);
        n = 0;
        got = 0;
        while (!got && n < 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            got = m ? m1_ready : m0_ready;
        end
        check("ready_timeout", got, 1);
        if (exp_lat > 0) check("ready_latency", n, exp_lat);
        @(posedge clk);
        #1 drive(m, 1'b0, 32'd0, 32'd0, 4'd0);
    endtask

    task automatic check_reset_outputs();
        check("rst_ready", {m0_ready, m1_ready}, 0);
        check("rst_m0_rdata", m0_rdata, 0);
        check("rst_m1_rdata", m1_rdata, 0);
        check("rst_ram", {ram_en, ram_we, ram_wdata}, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_io", {port_id, out_port, write_strobe, read_strobe}, 0);
        check("rst_m1_io_err", m1_io_err, 0);
    endtask

    initial begin
        int en0, ws0, rs0, rdy0;
        for (int i = 0; i < (1 << RAM_AW); i++) mem[i] = 32'd0;
        #400000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int en0, ws0, rs0, rdy0;
        // Reset values
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk);
        #1 resetn = 1'b1;

        // m0 full-word RAM write
        en0 = ram_en_cnt;
        txn(0, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'd0, 1, 2);
        check("w_ram_en_count", ram_en_cnt - en0, 1);
        check("w_ram_addr", last_ram_addr, 4);
        check("w_ram_we", last_ram_we, 4'hF);
        check("w_ram_wdata", last_ram_wdata, 32'hDEAD_BEEF);

        // m0 read back, then aliased address (word 0x804 -> 4)
        txn(0, 32'h0000_0010, 32'd0, 4'h0, 32'hDEAD_BEEF, 1, 2);
        check("r_ram_we", last_ram_we, 0);
        txn(0, 32'h0000_2010, 32'd0, 4'h0, 32'hDEAD_BEEF, 1, 2);
        check("alias_ram_addr", last_ram_addr, 4);

        // m1 byte write and read back
        txn(1, 32'h0000_0010, 32'h0000_00AA, 4'h1, 32'd0, 1, 2);
        check("byte_ram_we", last_ram_we, 4'h1);
        txn(1, 32'h0000_0010, 32'd0, 4'h0, 32'hDEAD_BEAA, 1, 2);
        check("m0_rdata_hold", m0_rdata, 32'hDEAD_BEEF);

        // Contention: last grant was m1, so order is m0, m1, m0, m1
        sb.push_back('{0, 32'hDEAD_BEAA});
        sb.push_back('{1, 32'h0000_0000});
        sb.push_back('{0, 32'h0000_0000});
        sb.push_back('{1, 32'h1234_5678});
        ready_cycles.delete();
        fork
            begin
                txn(0, 32'h0000_0010, 32'd0, 4'h0, 32'd0, 0, 0);
                txn(0, 32'h0000_0020, 32'h1234_5678, 4'hF, 32'd0, 0, 0);
            end
            begin
                txn(1, 32'h0000_0020, 32'd0, 4'h0, 32'd0, 0, 0);
                txn(1, 32'h0000_0020, 32'd0, 4'h0, 32'd0, 0, 0);
            end
        join
        check("contention_ready_count", ready_cycles.size(), 4);
        for (int i = 1; i < ready_cycles.size(); i++)
            check("contention_spacing", ready_cycles[i] - ready_cycles[i-1], 3);

        // I/O write and read
        en0 = ram_en_cnt; ws0 = ws_cnt; rs0 = rs_cnt;
        txn(0, 32'h8000_0008, 32'h0000_0055, 4'h1, 32'd0, 1, 2);
        check("io_w_strobe_count", ws_cnt - ws0, 1);
        check("io_w_port_id", last_port_id, 2);
        check("io_w_out_port", last_out_port, 8'h55);
        check("io_w_no_ram", ram_en_cnt - en0, 0);
        check("io_w_no_read_strobe", rs_cnt - rs0, 0);

        in_port = 8'h3C;
        rs0 = rs_cnt;
        txn(0, 32'h8000_0004, 32'd0, 4'h0, 32'h0000_003C, 1, 2);
        check("io_r_strobe_count", rs_cnt - rs0, 1);
        check("io_r_port_id", last_port_id, 1);

        // m1 I/O read: blocked unless the macro is defined
        check("m1_io_err_before", m1_io_err, 0);
        in_port = 8'h77;
        rs0 = rs_cnt;
`ifdef MEM_ARB_M1_IO_EN
        txn(1, 32'h8000_0000, 32'd0, 4'h0, 32'h0000_0077, 1, 2);
        check("m1_io_read_strobe", rs_cnt - rs0, 1);
        check("m1_io_err_after", m1_io_err, 0);
`else
        txn(1, 32'h8000_0000, 32'd0, 4'h0, 32'h0000_0000, 1, 2);
        check("m1_io_read_strobe", rs_cnt - rs0, 0);
        check("m1_io_err_after", m1_io_err, 1);
`endif
        check("m0_rdata_hold_io", m0_rdata, 32'h0000_003C);

        // I/O write with only upper strobes: no strobes, ready still returned
        ws0 = ws_cnt; rs0 = rs_cnt; en0 = ram_en_cnt;
        txn(0, 32'h8000_000C, 32'h0000_1100, 4'h2, 32'd0, 1, 2);
        check("io_hi_strobe_none", (ws_cnt - ws0) + (rs_cnt - rs0) + (ram_en_cnt - en0), 0);

        // Reset asserted during ISSUE: the transaction is dropped
        rdy0 = ready_cnt;
        drive(0, 1'b1, 32'h0000_0010, 32'd0, 4'h0);
        @(posedge clk);
        #1 resetn = 1'b0;
        @(posedge clk);
        #1 drive(0, 1'b0, 32'd0, 32'd0, 4'd0);
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk);
        #1 resetn = 1'b1;
        repeat (4) @(posedge clk);
        #1 check("mid_reset_no_ready", ready_cnt - rdy0, 0);

        // After reset FSM is idle and m0 wins the first tie
        sb.push_back('{0, 32'hDEAD_BEAA});
        sb.push_back('{1, 32'h1234_5678});
        fork
            txn(0, 32'h0000_0010, 32'd0, 4'h0, 32'd0, 0, 2);
            txn(1, 32'h0000_0020, 32'd0, 4'h0, 32'd0, 0, 0);
        join

        repeat (4) @(posedge clk);
        @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
